lab3_digit_display: RTL and testbench
=====================================

# lab3_digit_display

Downstream consumer of the keypad scanner/debouncer. Samples the scanner's debounced `keypress` code on each new press (rising edge of `alarm`) and decodes the one-hot-low {cols, rows} code to a hex digit. Keeps the two most recent digits in a history register and drives a time-multiplexed pair of seven-segment displays, with the newest digit on the right.

## Interface
Parameters:
- `REFRESH_DIV`, default 24000: `int_osc` cycles per display-select toggle. Minimum 2.
- `CW`, default 15: refresh counter width. Must satisfy 2^CW >= REFRESH_DIV.

Ports:
- `int_osc`  in  1  system clock, the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `keypress`  in  8  {cols[3:0], rows[3:0]} from the scanner. Each nibble is one-hot-low when valid.
- `alarm`  in  1  scanner "press confirmed" level. Stays high while the key is held.
- `seg`  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- `an`  out  2  active-low digit enables. an[0] is the right digit (newest), an[1] is the left digit (older).
- `digit_new`  out  4  most recent decoded digit.
- `digit_old`  out  4  previous decoded digit.
- `key_strobe`  out  1  one-cycle pulse, high in the cycle the history registers first show a new digit.

## Operation
- Edge detect:
  - `alarm_q` registers `alarm` every cycle.
  - A press event is `alarm & ~alarm_q`.
  - Holding `alarm` high produces exactly one event.
- Decode:
  - c = index of the single 0 in keypress[7:4]; r = index of the single 0 in keypress[3:0].
  - Layout by row r (c = 0..3):
    - r0: 1 2 3 A
    - r1: 4 5 6 B
    - r2: 7 8 9 C
    - r3: E 0 F D
  - A nibble with zero or more than one 0 bit is invalid.
- Shift: on an event with a valid decode:
  - `digit_old` <= `digit_new`, `old_valid` <= `new_valid`.
  - `digit_new` <= decoded value, `new_valid` <= 1.
  - `key_strobe` <= 1.
- Invalid event: no shift, no strobe. `alarm_q` still updates, so the same held press never retries.
- Display:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0.
  - `sel` toggles on the wrap cycle.
  - sel=0: an=2'b10, shows the `digit_new` slot. sel=1: an=2'b01, shows the `digit_old` slot.
  - A slot whose valid bit is 0 shows blank: seg=7'h7F.
- Hex font, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E
- `seg` and `an` are combinational from `sel`, the digit registers and the valid bits. No other outputs are combinational.

## Timing
- Reset values (`reset` high at an edge; valid the cycle after):
  - `alarm_q`=0, `digit_new`=0, `digit_old`=0, both valid bits 0.
  - `key_strobe`=0, counter=0, sel=0.
  - Resulting outputs: an=2'b10, seg=7'h7F.
- Latency: event seen at edge N → digits, valid bits and `key_strobe` update at edge N+1. `seg` reflects the new digit in the same cycle, provided that slot is selected.
- `key_strobe` is high for exactly one cycle per accepted press.
- Refresh: `sel` period is 2·REFRESH_DIV cycles. Each digit is shown for REFRESH_DIV cycles.
- Event in the same cycle as a refresh wrap: both take effect at the same edge, independently.
- `alarm` high while `reset` is asserted: `alarm_q` is forced to 0 during reset. The first cycle after reset therefore detects an event if `alarm` is still high.
- Reset mid-display or mid-hold: all state returns to reset values immediately; no partial shift.
- Back-to-back presses separated by a single low cycle of `alarm` are both accepted.

## Test plan
- Reset then idle 3·REFRESH_DIV cycles (REFRESH_DIV=4 in the bench) → seg=7'h7F throughout; an alternates 10/01 every 4 cycles; key_strobe stays 0.
- keypress=8'hEE (c0,r0), alarm rises → one cycle later digit_new=1, key_strobe pulses once, seg=7'h79 while an=10; left digit stays blank.
- Then keypress=8'hD7 (c1,r3) with a new alarm rise → digit_new=0, digit_old=1; right digit seg=7'h40, left digit seg=7'h79.
- Hold alarm high for 100 cycles → exactly one key_strobe; digits unchanged after the first shift.
- keypress=8'hCE (two columns low) with an alarm rise → no shift, no strobe.
- Assert reset mid-hold with two valid digits → all registers clear; if alarm is still high on release, one event is accepted on the first post-reset cycle.

Source files
------------

// File: rtl/lab3_digit_display.sv
// lab3_digit_display: takes debounced keypad codes from the scanner, keeps the
// two most recent hex digits and drives a two-digit multiplexed 7-seg display.
// The newest digit is on the right (an[0]) and the older one is on the left (an[1]).

// Hex to active-low seven-segment font, bit order {g,f,e,d,c,b,a}.
// When blank is high, every segment is turned off.
module lab3_hex7seg (
    input  logic       blank,
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    // font lookup with blanking override
    always_comb begin
        seg = 7'h7F;
        if (!blank) begin
            case (digit)
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                default: seg = 7'h0E;
            endcase
        end
    end
endmodule

module lab3_digit_display #(
    parameter int REFRESH_DIV = 24000,
    parameter int CW          = 15
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [7:0] keypress,
    input  logic       alarm,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_strobe
);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic          alarm_q;
    logic          press_evt;
    logic          new_valid;
    logic          old_valid;
    logic [CW-1:0] refresh_cnt;
    logic          sel;

    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic          col_ok;
    logic          row_ok;
    logic [3:0]    dec_digit;
    logic          dec_ok;

    logic [3:0]    show_digit;
    logic          show_blank;

    // A new press is the first cycle in which alarm is high. Holding the key
    // keeps alarm_q high, so the same press never fires a second event.
    assign press_evt = alarm & ~alarm_q;

    // Column and row indices come from one-hot-low nibbles. Any other
    // pattern (no bit low, or several bits low) is rejected.
    always_comb begin
        col_idx = 2'd0;
        col_ok  = 1'b1;
        case (keypress[7:4])
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_ok  = 1'b0;
        endcase
        row_idx = 2'd0;
        row_ok  = 1'b1;
        case (keypress[3:0])
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
    end

    // Keypad layout: row 0 = 1 2 3 A, row 1 = 4 5 6 B, row 2 = 7 8 9 C,
    // row 3 = E 0 F D (index order is {row, col}).
    always_comb begin
        dec_ok = col_ok & row_ok;
        case ({row_idx, col_idx})
            4'b00_00: dec_digit = 4'h1;
            4'b00_01: dec_digit = 4'h2;
            4'b00_10: dec_digit = 4'h3;
            4'b00_11: dec_digit = 4'hA;
            4'b01_00: dec_digit = 4'h4;
            4'b01_01: dec_digit = 4'h5;
            4'b01_10: dec_digit = 4'h6;
            4'b01_11: dec_digit = 4'hB;
            4'b10_00: dec_digit = 4'h7;
            4'b10_01: dec_digit = 4'h8;
            4'b10_10: dec_digit = 4'h9;
            4'b10_11: dec_digit = 4'hC;
            4'b11_00: dec_digit = 4'hE;
            4'b11_01: dec_digit = 4'h0;
            4'b11_10: dec_digit = 4'hF;
            default:  dec_digit = 4'hD;
        endcase
    end

    // Edge detector and two-deep digit history. A valid press shifts the
    // history and raises a one-cycle strobe. An invalid press is dropped,
    // but alarm_q still tracks alarm so a held bad code is not retried.
    always_ff @(posedge int_osc) begin
        if (reset) begin
            alarm_q    <= 1'b0;
            digit_new  <= 4'h0;
            digit_old  <= 4'h0;
            new_valid  <= 1'b0;
            old_valid  <= 1'b0;
            key_strobe <= 1'b0;
        end else begin
            alarm_q    <= alarm;
            key_strobe <= press_evt & dec_ok;
            if (press_evt && dec_ok) begin
                digit_old <= digit_new;
                old_valid <= new_valid;
                digit_new <= dec_digit;
                new_valid <= 1'b1;
            end
        end
    end

    // Refresh divider. The select bit flips on each wrap, so every digit is
    // lit for REFRESH_DIV cycles. This runs independently of the key path.
    always_ff @(posedge int_osc) begin
        if (reset) begin
            refresh_cnt <= '0;
            sel         <= 1'b0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            sel         <= ~sel;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Select the slot being shown. A slot that has never been filled is blank.
    always_comb begin
        an         = sel ? 2'b01 : 2'b10;
        show_digit = sel ? digit_old : digit_new;
        show_blank = sel ? ~old_valid : ~new_valid;
    end

    lab3_hex7seg u_font (
        .blank (show_blank),
        .digit (show_digit),
        .seg   (seg)
    );
endmodule

// File: tb/tb_lab3_digit_display.sv
// Directed bench for lab3_digit_display with REFRESH_DIV=4.
module tb_lab3_digit_display;
    logic       int_osc = 1'b0;
    logic       reset;
    logic [7:0] keypress;
    logic       alarm;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_strobe;

    int n_cmp = 0;
    int n_err = 0;

    // expected state
    logic [3:0] e_new, e_old;
    logic       e_nv, e_ov, e_strobe;
    int         e_cnt;
    logic       e_sel;

    lab3_digit_display #(.REFRESH_DIV(4), .CW(3)) dut (
        .int_osc    (int_osc),
        .reset      (reset),
        .keypress   (keypress),
        .alarm      (alarm),
        .seg        (seg),
        .an         (an),
        .digit_new  (digit_new),
        .digit_old  (digit_old),
        .key_strobe (key_strobe)
    );

    always #5 int_osc = ~int_osc;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Clock one edge, advance the refresh model, then settle before sampling.
    task automatic step();
        @(posedge int_osc);
        if (reset) begin
            e_cnt = 0; e_sel = 1'b0;
        end else if (e_cnt == 3) begin
            e_cnt = 0; e_sel = ~e_sel;
        end else begin
            e_cnt++;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [6:0] e_seg;
        if (e_sel) e_seg = e_ov ? font(e_old) : 7'h7F;
        else       e_seg = e_nv ? font(e_new) : 7'h7F;
        chk({tag, ".an"},     {6'd0, an},         {6'd0, e_sel ? 2'b01 : 2'b10});
        chk({tag, ".seg"},    {1'b0, seg},        {1'b0, e_seg});
        chk({tag, ".new"},    {4'd0, digit_new},  {4'd0, e_new});
        chk({tag, ".old"},    {4'd0, digit_old},  {4'd0, e_old});
        chk({tag, ".strobe"}, {7'd0, key_strobe}, {7'd0, e_strobe});
    endtask

    // Apply a rising alarm with code kp; expect acceptance of digit d.
    task automatic press_ok(input string tag, input logic [7:0] kp, input logic [3:0] d);
        keypress = kp; alarm = 1'b1;
        step();
        e_old = e_new; e_ov = e_nv; e_new = d; e_nv = 1'b1; e_strobe = 1'b1;
        check_all({tag, ".accept"});
        step();
        e_strobe = 1'b0;
        check_all({tag, ".after"});
    endtask

    initial begin
        reset = 1'b1; alarm = 1'b0; keypress = 8'hFF;
        e_new = 4'h0; e_old = 4'h0; e_nv = 1'b0; e_ov = 1'b0; e_strobe = 1'b0;
        e_cnt = 0; e_sel = 1'b0;
        step(); step();
        check_all("reset");
        reset = 1'b0;

        // idle: blank display, select alternates every 4 cycles
        for (int i = 0; i < 12; i++) begin
            step();
            check_all("idle");
        end

        // c0,r0 -> 1, then c1,r3 -> 0
        press_ok("key1", 8'hEE, 4'h1);
        alarm = 1'b0; step(); check_all("rel1");
        press_ok("key0", 8'hD7, 4'h0);

        // hold alarm high: no further events
        for (int i = 0; i < 100; i++) begin
            step();
            check_all("hold");
        end
        alarm = 1'b0; step(); check_all("rel_hold");

        // two columns low: rejected
        keypress = 8'hCE; alarm = 1'b1;
        step(); check_all("bad");
        step(); check_all("bad_hold");
        alarm = 1'b0; step(); check_all("bad_rel");

        // back-to-back presses with a single low cycle in between: 6 then A
        press_ok("key6", 8'hBD, 4'h6);
        alarm = 1'b0; step(); check_all("gap");
        press_ok("keyA", 8'h7E, 4'hA);

        // reset during a hold, with both slots valid
        keypress = 8'h7B; reset = 1'b1;
        step();
        e_new = 4'h0; e_old = 4'h0; e_nv = 1'b0; e_ov = 1'b0; e_strobe = 1'b0;
        check_all("mid_reset");
        reset = 1'b0;
        // alarm still high: first post-reset cycle sees an event (c3,r2 -> C)
        step();
        e_old = 4'h0; e_ov = 1'b0; e_new = 4'hC; e_nv = 1'b1; e_strobe = 1'b1;
        check_all("post_reset");
        step(); e_strobe = 1'b0; check_all("post_reset_hold");
        for (int i = 0; i < 6; i++) begin
            step();
            check_all("tail");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
